// File: rtl/nbit_adder.sv
// nbit_adder: N-bit ripple-carry adder with registered sum, carry-out, signed overflow and valid
module nbit_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic         in_valid,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         out_valid
);
    logic [N:0]   c;
    logic [N-1:0] s;
    assign c[0] = c_in;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= s;
                c_out    <= c[N];
                overflow <= c[N] ^ c[N-1];
            end
        end
    end
endmodule

// File: tb/tb_nbit_adder.sv
// tb_nbit_adder: directed vector table plus reset/hold sequences for nbit_adder
module tb_nbit_adder;
    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       c_in;
        logic [3:0] e_sum;
        logic       e_co;
        logic       e_ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       c_in = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] sum;
    logic       c_out;
    logic       overflow;
    logic       out_valid;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       vt[10];

    nbit_adder #(.N(4)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .c_in(c_in), .in_valid(in_valid),
        .sum(sum), .c_out(c_out), .overflow(overflow), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
        @(negedge clk);
        x = a; y = b; c_in = ci; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vt[1] = '{4'b1000, 4'b0010, 1'b0, 4'b1010, 1'b0, 1'b0};
        vt[2] = '{4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1, 1'b1};
        vt[3] = '{4'b0010, 4'b0001, 1'b1, 4'b0100, 1'b0, 1'b0};
        vt[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        vt[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vt[6] = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b1};
        vt[7] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        vt[8] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vt[9] = '{4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0};

        #12;
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(c_out), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply(vt[i].x, vt[i].y, vt[i].c_in, 1'b1);
            check($sformatf("v%0d_sum", i), 32'(sum), 32'(vt[i].e_sum));
            check($sformatf("v%0d_cout", i), 32'(c_out), 32'(vt[i].e_co));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ov));
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
        end

        apply(4'b0011, 4'b0011, 1'b0, 1'b0);
        check("hold_sum", 32'(sum), 32'd0);
        check("hold_cout", 32'(c_out), 32'd1);
        check("hold_valid", 32'(out_valid), 32'd0);

        apply(4'b0101, 4'b0011, 1'b0, 1'b1);
        check("pre_rst_sum", 32'(sum), 32'b1000);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_sum", 32'(sum), 32'd0);

        apply(4'b0001, 4'b0001, 1'b0, 1'b1);
        check("first_after_rst_sum", 32'(sum), 32'b0010);
        check("first_after_rst_valid", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
